// File: rtl/ext_slave_obi_guard.sv
// OBI guard between the mochila external slave port and the SoC slave:
// registered request slice, outstanding-credit limit and response watchdog.
module ext_slave_obi_guard #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] ERR_RDATA       = 32'hBADCAB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_req_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_be_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_gnt_o,
    output logic        s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic        clr_timeout_i,
    output logic        timeout_o,
    output logic [7:0]  timeout_cnt_o,
    output logic        busy_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [4:0] MAX_W = 5'(MAX_OUTSTANDING);
    localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

    logic        buf_valid;
    logic        buf_we;
    logic [3:0]  buf_be;
    logic [31:0] buf_addr;
    logic [31:0] buf_wdata;
    logic [3:0]  cnt;
    logic [3:0]  issued;
    logic [3:0]  drop;
    logic [TW-1:0] timer;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        flag_q;
    logic [7:0]  tcnt_q;

    logic credit_ok, gnt, accept, handshake;
    logic has_drop, has_issued, rv_drop, rv_fwd, timeout, retire;

    always_comb begin
        credit_ok  = ({1'b0, cnt} + {1'b0, drop}) < MAX_W;
        gnt        = !rst_i && credit_ok && (!buf_valid || m_gnt_i);
        accept     = s_req_i && gnt;
        handshake  = buf_valid && m_gnt_i;
        has_drop   = (drop != 4'd0);
        has_issued = (issued != 4'd0);
        rv_drop    = m_rvalid_i && has_drop;
        rv_fwd     = m_rvalid_i && !has_drop && has_issued;
        // A real rvalid in the terminal cycle beats the synthesized error.
        timeout    = WD_EN && has_issued && !m_rvalid_i && (timer == '0);
        retire     = rv_fwd || timeout;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid <= 1'b0;
            buf_we    <= 1'b0;
            buf_be    <= 4'd0;
            buf_addr  <= 32'd0;
            buf_wdata <= 32'd0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_we    <= s_we_i;
            buf_be    <= s_be_i;
            buf_addr  <= s_addr_i;
            buf_wdata <= s_wdata_i;
        end else if (handshake) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= 4'd0;
            issued <= 4'd0;
            drop   <= 4'd0;
        end else begin
            cnt    <= cnt + 4'(accept) - 4'(retire);
            issued <= issued + 4'(handshake) - 4'(retire);
            drop   <= drop + 4'(timeout) - 4'(rv_drop);
        end
    end

    // Down-counter reloaded whenever the oldest issued transaction changes or none is pending.
    always_ff @(posedge clk_i) begin
        if (rst_i || !has_issued || m_rvalid_i || timeout) begin
            timer <= TIMER_LOAD;
        end else begin
            timer <= timer - TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= retire;
            if (rv_fwd) begin
                rdata_q <= m_rdata_i;
            end else if (timeout) begin
                rdata_q <= ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
            tcnt_q <= 8'd0;
        end else if (timeout) begin
            flag_q <= 1'b1;
            if (clr_timeout_i) begin
                tcnt_q <= 8'd1;
            end else if (tcnt_q != 8'hFF) begin
                tcnt_q <= tcnt_q + 8'd1;
            end
        end else if (clr_timeout_i) begin
            flag_q <= 1'b0;
            tcnt_q <= 8'd0;
        end
    end

    assign s_gnt_o       = gnt;
    assign s_rvalid_o    = rvalid_q;
    assign s_rdata_o     = rdata_q;
    assign m_req_o       = buf_valid;
    assign m_we_o        = buf_we;
    assign m_be_o        = buf_be;
    assign m_addr_o      = buf_addr;
    assign m_wdata_o     = buf_wdata;
    assign timeout_o     = flag_q;
    assign timeout_cnt_o = tcnt_q;
    assign busy_o        = buf_valid || (cnt != 4'd0) || has_drop;

endmodule

// File: tb/tb_ext_slave_obi_guard.sv
// Directed bench for ext_slave_obi_guard (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=8).
module tb_ext_slave_obi_guard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        s_req_i, s_we_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_addr_i, s_wdata_i;
    logic        s_gnt_o, s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        m_req_o, m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic        m_gnt_i, m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic        clr_timeout_i;
    logic        timeout_o;
    logic [7:0]  timeout_cnt_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    ext_slave_obi_guard #(
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hBADCAB1E)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i),
        .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
        .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .clr_timeout_i(clr_timeout_i), .timeout_o(timeout_o),
        .timeout_cnt_o(timeout_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    logic [9:0] gvec;
    logic [8:0] rvec;
    int         k;

    initial begin
        rst_i = 1'b1; s_req_i = 1'b0; s_we_i = 1'b0; s_be_i = 4'hF;
        s_addr_i = '0; s_wdata_i = '0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
        m_rdata_i = '0; clr_timeout_i = 1'b0;
        tick(); tick();
        check_eq("rst_gnt", 32'(s_gnt_o), 0);
        check_eq("rst_mreq", 32'(m_req_o), 0);
        check_eq("rst_rvalid", 32'(s_rvalid_o), 0);
        check_eq("rst_rdata", s_rdata_o, 0);
        check_eq("rst_tflag", 32'(timeout_o), 0);
        check_eq("rst_tcnt", 32'(timeout_cnt_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;

        // single read
        m_gnt_i = 1'b1; s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h2000_0010;
        #1 check_eq("t1_gnt", 32'(s_gnt_o), 1);
        tick();
        s_req_i = 1'b0;
        check_eq("t1_mreq", 32'(m_req_o), 1);
        check_eq("t1_maddr", m_addr_o, 32'h2000_0010);
        tick();
        check_eq("t1_mreq_clr", 32'(m_req_o), 0);
        check_eq("t1_busy", 32'(busy_o), 1);
        tick(); tick();
        m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678;
        #1 check_eq("t1_rvalid_early", 32'(s_rvalid_o), 0);
        tick();
        m_rvalid_i = 1'b0;
        check_eq("t1_rvalid", 32'(s_rvalid_o), 1);
        check_eq("t1_rdata", s_rdata_o, 32'h1234_5678);
        check_eq("t1_busy_done", 32'(busy_o), 0);
        tick();
        check_eq("t1_rvalid_pulse", 32'(s_rvalid_o), 0);

        // back-pressure and credit limit
        k = 0; gvec = '0;
        for (int i = 1; i <= 10; i++) begin
            m_gnt_i = (i >= 6); s_req_i = 1'b1; s_we_i = 1'b1;
            s_addr_i = 32'h4000_0000 + 32'(k); s_wdata_i = 32'(k);
            #1;
            gvec[i-1] = s_gnt_o;
            if (i >= 2 && i <= 5) begin
                check_eq("t2_stall_req", 32'(m_req_o), 1);
                check_eq("t2_stall_addr", m_addr_o, 32'h4000_0000);
                check_eq("t2_stall_we", 32'(m_we_o), 1);
            end
            if (s_gnt_o) k++;
            tick();
        end
        check_eq("t2_gnt_pattern", 32'(gvec), 32'h0E1);
        check_eq("t2_accepts", 32'(k), 4);
        s_addr_i = 32'h4000_0004; m_rvalid_i = 1'b1; m_rdata_i = 32'h11;
        #1 check_eq("t2_gnt_full", 32'(s_gnt_o), 0);
        tick();
        s_req_i = 1'b0; s_we_i = 1'b0; m_rdata_i = 32'h12;
        check_eq("t2_rvalid1", 32'(s_rvalid_o), 1);
        check_eq("t2_gnt_freed", 32'(s_gnt_o), 1);
        tick();
        m_rdata_i = 32'h13; tick();
        m_rdata_i = 32'h14; tick();
        m_rvalid_i = 1'b0;
        check_eq("t2_rvalid4", 32'(s_rvalid_o), 1);
        check_eq("t2_rdata4", s_rdata_o, 32'h14);
        check_eq("t2_busy", 32'(busy_o), 0);
        tick();

        // timeout
        s_req_i = 1'b1; s_addr_i = 32'h3000_0000;
        tick();
        s_req_i = 1'b0;
        tick();
        rvec = '0;
        for (int i = 0; i < 9; i++) begin
            rvec[i] = s_rvalid_o;
            if (i < 8) tick();
        end
        check_eq("t3_rvalid_timing", 32'(rvec), 32'h100);
        check_eq("t3_err_rdata", s_rdata_o, 32'hBADCAB1E);
        check_eq("t3_tflag", 32'(timeout_o), 1);
        check_eq("t3_tcnt", 32'(timeout_cnt_o), 1);
        check_eq("t3_busy_drop", 32'(busy_o), 1);
        m_rvalid_i = 1'b1; m_rdata_i = 32'hAAAA_5555;
        tick();
        m_rvalid_i = 1'b0;
        check_eq("t3_late_dropped", 32'(s_rvalid_o), 0);
        check_eq("t3_busy_after", 32'(busy_o), 0);

        // clear coinciding with a second timeout
        s_req_i = 1'b1; s_addr_i = 32'h3000_0004;
        tick();
        s_req_i = 1'b0;
        tick();
        repeat (7) tick();
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
        check_eq("t3b_rvalid", 32'(s_rvalid_o), 1);
        check_eq("t3b_tflag", 32'(timeout_o), 1);
        check_eq("t3b_tcnt", 32'(timeout_cnt_o), 1);
        m_rvalid_i = 1'b1; m_rdata_i = 32'hAAAA_5555;
        tick();
        m_rvalid_i = 1'b0;
        check_eq("t3b_busy", 32'(busy_o), 0);

        // clear, then rvalid racing the timeout cycle
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
        check_eq("t4_clr_flag", 32'(timeout_o), 0);
        check_eq("t4_clr_cnt", 32'(timeout_cnt_o), 0);
        s_req_i = 1'b1; s_addr_i = 32'h3000_0008;
        tick();
        s_req_i = 1'b0;
        tick();
        repeat (7) tick();
        m_rvalid_i = 1'b1; m_rdata_i = 32'h5A5A_0001;
        tick();
        m_rvalid_i = 1'b0;
        check_eq("t4_rvalid", 32'(s_rvalid_o), 1);
        check_eq("t4_rdata", s_rdata_o, 32'h5A5A_0001);
        check_eq("t4_tflag", 32'(timeout_o), 0);
        check_eq("t4_busy", 32'(busy_o), 0);
        tick();

        // pipelined in-order reads
        s_req_i = 1'b1; s_addr_i = 32'h5000_0000;
        #1 check_eq("t5_gnt_a", 32'(s_gnt_o), 1);
        tick();
        s_addr_i = 32'h5000_0004;
        #1 check_eq("t5_gnt_b", 32'(s_gnt_o), 1);
        tick();
        s_addr_i = 32'h5000_0008;
        #1 check_eq("t5_gnt_c", 32'(s_gnt_o), 1);
        tick();
        s_req_i = 1'b0;
        check_eq("t5_maddr_c", m_addr_o, 32'h5000_0008);
        tick();
        m_rvalid_i = 1'b1; m_rdata_i = 32'd1;
        tick();
        check_eq("t5_rv1", 32'(s_rvalid_o), 1);
        check_eq("t5_rd1", s_rdata_o, 32'd1);
        m_rdata_i = 32'd2;
        tick();
        check_eq("t5_rv2", 32'(s_rvalid_o), 1);
        check_eq("t5_rd2", s_rdata_o, 32'd2);
        m_rdata_i = 32'd3;
        tick();
        check_eq("t5_rv3", 32'(s_rvalid_o), 1);
        check_eq("t5_rd3", s_rdata_o, 32'd3);
        m_rvalid_i = 1'b0;
        tick();
        check_eq("t5_rv_end", 32'(s_rvalid_o), 0);
        check_eq("t5_busy", 32'(busy_o), 0);

        // reset mid-flight: two issued, one buffered
        s_req_i = 1'b1; s_addr_i = 32'h6000_0000;
        tick();
        s_addr_i = 32'h6000_0004;
        tick();
        s_addr_i = 32'h6000_0008;
        tick();
        s_req_i = 1'b0; m_gnt_i = 1'b0;
        check_eq("t6_busy_pre", 32'(busy_o), 1);
        check_eq("t6_mreq_pre", 32'(m_req_o), 1);
        rst_i = 1'b1;
        tick();
        check_eq("t6_gnt", 32'(s_gnt_o), 0);
        check_eq("t6_mreq", 32'(m_req_o), 0);
        check_eq("t6_rvalid", 32'(s_rvalid_o), 0);
        check_eq("t6_rdata", s_rdata_o, 0);
        check_eq("t6_busy", 32'(busy_o), 0);
        rst_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
        tick();
        m_rvalid_i = 1'b0;
        check_eq("t6_stray_ignored", 32'(s_rvalid_o), 0);
        check_eq("t6_busy_after", 32'(busy_o), 0);
        check_eq("t6_tflag", 32'(timeout_o), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
